regfile_writeback: RTL
======================

# regfile_writeback

Write-side initiator for the 16×32-bit register bank: accepts results from the ALU and memory stages via valid/ready handshakes, buffers them in a 4-entry in-order queue, and drives the bank's write port (`wr_en`, `dest`, `Din`) at one write per cycle. It also reports read-after-write hazards so decode can stall while a source register has a write still in the queue.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; must be a power of two and at least 2.
- `AW`, 4: register address width.
- `DW`, 32: data width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  ALU result valid.
- `alu_dest`  in  AW  ALU destination register.
- `alu_data`  in  DW  ALU result.
- `alu_ready`  out  1  ALU result accepted this cycle when high together with `alu_valid`.
- `mem_valid`, `mem_dest`, `mem_data`, `mem_ready`: the same set for the memory stage.
- `wb_hold`  in  1  bank busy; suppress the write and hold the head entry.
- `wr_en`  out  1  bank write strobe.
- `dest`  out  AW  bank write address.
- `Din`  out  DW  bank write data.
- `chk_addr1`, `chk_addr2`  in  AW  source addresses from decode.
- `hazard1`, `hazard2`  out  1  the matching `chk_addr` equals the dest of some valid queue entry.
- `level`  out  3  queue occupancy, 0..4.
- `idle`  out  1  queue empty.

## Operation
- Circular queue: write pointer, read pointer, occupancy counter. The pointers wrap modulo DEPTH.
- Free space: `space = DEPTH - level`, taken from the registered level. A pop in the same cycle does not free space for that cycle's push.
- `mem_ready = (space >= 1)`.
- `alu_ready = mem_valid ? (space >= 2) : (space >= 1)`. Memory has priority.
- Both sources accepted in one cycle:
  - The MEM entry enqueues first and the ALU entry second.
  - If both have the same dest, the ALU value is written last and is the final value in the bank.
- Pop: when `level != 0 && !wb_hold`, the head entry is written to the bank and `rd_ptr` advances.
- Outputs are driven from registered head state:
  - `wr_en = (level != 0) && !wb_hold`.
  - `dest` and `Din` show the head entry when `wr_en` is high; otherwise both are 0. They are never driven to z.
- Pushes and a pop in the same cycle are legal. The new level is `level + pushes - pop`.
- Hazard checks are combinational: `chk_addr` is compared against all valid entries. An entry popping this cycle still counts.
- `idle = (level == 0)`.
- Accepting while full is impossible, because ready is low whenever space is short.

## Timing
- Reset is asynchronous and takes effect immediately. On reset:
  - Pointers and `level` are 0, and all entry valid bits are cleared.
  - `wr_en=0`, `dest=0`, `Din=0`, `hazard1=hazard2=0`, `idle=1`.
  - `alu_ready=mem_ready=1`.
- Reset during operation flushes all queued writes; none of them reach the bank.
- Latency: a result accepted at edge N produces `wr_en` in cycle N+1 when the queue was empty and `wb_hold` is low. In general it is written in FIFO order.
- Throughput: 1 write per cycle sustained. Up to 2 accepts per cycle.
- `wb_hold` high means no pop that cycle. `dest` and `Din` drop to 0 while the head is preserved.

## Configuration
- `REGFILE_WB_R0_ZERO_EN`
  - Defined: a result whose dest is 0 is still handshaken (ready behaves as normal) but is not enqueued and uses no space. `chk_addr == 0` never raises a hazard.
  - Undefined: register 0 is ordinary. Its writes are queued and checked like any other register.

## Test plan
- Single write: after reset, `alu_valid=1`, `alu_dest=1`, `alu_data=1` for one cycle → next cycle `wr_en=1`, `dest=1`, `Din=1`; the following cycle `wr_en=0`, `dest=0`, `Din=0`, `idle=1`.
- Dual accept with same dest:
  - Stimulus: MEM (dest 4, 19) and ALU (dest 4, 7) in the same cycle.
  - Response: two consecutive writes, 19 then 7. `hazard1=1` for `chk_addr1=4` until the second write pops.
- Fill and back-pressure:
  - Stimulus: `wb_hold=1`, then 4 ALU pushes.
  - Response: `level=4`, `alu_ready=0`, `mem_ready=0`. After releasing hold, 4 writes in order on consecutive cycles and `level` counts down to 0.
- Space=1 arbitration: `level=3`, both sources valid → only MEM is accepted (`alu_ready=0`) and `level` becomes 4.
- Reset mid-operation: with 3 queued entries, assert `rst_n=0` asynchronously between edges → outputs go to reset values immediately, and no `wr_en` occurs after release.
- With `REGFILE_WB_R0_ZERO_EN` defined: ALU push to dest 0 → `alu_ready=1`, `level` stays 0, no `wr_en`, `hazard1=0` for `chk_addr1=0`.

Source files
------------

// File: rtl/regfile_writeback.sv
// Write-back queue feeding the 16x32 register bank: merges ALU/MEM results in order and flags RAW hazards.
// Optional build macro REGFILE_WB_R0_ZERO_EN: writes to register 0 are handshaken but dropped, and r0 never hazards.
module regfile_writeback #(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [AW-1:0]            alu_dest,
  input  logic [DW-1:0]            alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [AW-1:0]            mem_dest,
  input  logic [DW-1:0]            mem_data,
  output logic                     mem_ready,
  input  logic                     wb_hold,
  output logic                     wr_en,
  output logic [AW-1:0]            dest,
  output logic [DW-1:0]            Din,
  input  logic [AW-1:0]            chk_addr1,
  input  logic [AW-1:0]            chk_addr2,
  output logic                     hazard1,
  output logic                     hazard2,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] ONE_L   = LW'(1);
  localparam logic [LW-1:0] TWO_L   = LW'(2);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, alu_slot_s;
  logic [LW-1:0]    level_q, level_d, space_s;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]    dest_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic             mem_keep_s, alu_keep_s, mem_push_s, alu_push_s, pop_s;

`ifdef REGFILE_WB_R0_ZERO_EN
  assign mem_keep_s = (mem_dest != {AW{1'b0}});
  assign alu_keep_s = (alu_dest != {AW{1'b0}});
`else
  assign mem_keep_s = 1'b1;
  assign alu_keep_s = 1'b1;
`endif

  // Handshake, push/pop decisions and next-state for pointers, level and valid bits.
  always_comb begin
    space_s    = DEPTH_L - level_q;
    mem_ready  = (space_s >= ONE_L);
    alu_ready  = mem_valid ? (space_s >= TWO_L) : (space_s >= ONE_L);
    mem_push_s = mem_valid && mem_ready && mem_keep_s;
    alu_push_s = alu_valid && alu_ready && alu_keep_s;
    pop_s      = (level_q != {LW{1'b0}}) && !wb_hold;
    // MEM takes the first free slot so a same-dest ALU result lands after it.
    alu_slot_s = mem_push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    wr_ptr_d   = wr_ptr_q + PW'(mem_push_s) + PW'(alu_push_s);
    rd_ptr_d   = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    level_d    = level_q + LW'(mem_push_s) + LW'(alu_push_s) - LW'(pop_s);
    valid_d    = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = (mem_push_s && (wr_ptr_q == PW'(i))) ||
                   (alu_push_s && (alu_slot_s == PW'(i))) ||
                   (valid_q[i] && !(pop_s && (rd_ptr_q == PW'(i))));
    end
  end

  // Queue state and entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      level_q  <= {LW{1'b0}};
      valid_q  <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= {AW{1'b0}};
        data_q[i] <= {DW{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (mem_push_s && (wr_ptr_q == PW'(i))) begin
          dest_q[i] <= mem_dest;
          data_q[i] <= mem_data;
        end else if (alu_push_s && (alu_slot_s == PW'(i))) begin
          dest_q[i] <= alu_dest;
          data_q[i] <= alu_data;
        end else begin
          dest_q[i] <= dest_q[i];
          data_q[i] <= data_q[i];
        end
      end
    end
  end

  // Bank write port and status, all decoded from registered queue state.
  always_comb begin
    wr_en = (level_q != {LW{1'b0}}) && !wb_hold;
    if (wr_en) begin
      dest = dest_q[rd_ptr_q];
      Din  = data_q[rd_ptr_q];
    end else begin
      dest = {AW{1'b0}};
      Din  = {DW{1'b0}};
    end
    level = level_q;
    idle  = (level_q == {LW{1'b0}});
  end

  // RAW hazard lookup; the entry being written this cycle still counts.
  always_comb begin
    hazard1 = 1'b0;
    hazard2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hazard1 = hazard1 || (valid_q[i] && (dest_q[i] == chk_addr1));
      hazard2 = hazard2 || (valid_q[i] && (dest_q[i] == chk_addr2));
    end
`ifdef REGFILE_WB_R0_ZERO_EN
    hazard1 = hazard1 && (chk_addr1 != {AW{1'b0}});
    hazard2 = hazard2 && (chk_addr2 != {AW{1'b0}});
`endif
  end

endmodule
